// File: rtl/obf_seq_ctrl.sv
// obf_seq_ctrl: walks the substitution LUT pseudo-PC per obfuscated fetch, freezing fetch until retire or flush
module obf_seq_ctrl #(
  parameter int IGU_WIDTH     = 7,
  parameter int PPC_WIDTH     = 4,
  parameter int LUT_OUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [IGU_WIDTH-1:0]     req_index,
  input  logic [PPC_WIDTH-1:0]     req_len,
  output logic                     req_ready,
  output logic [IGU_WIDTH-1:0]     lut_index,
  output logic [PPC_WIDTH-1:0]     lut_ppc,
  input  logic [LUT_OUT_WIDTH-1:0] lut_sub,
  input  logic [LUT_OUT_WIDTH-1:0] lut_imm,
  output logic                     sub_valid,
  output logic [LUT_OUT_WIDTH-1:0] sub_word,
  output logic [LUT_OUT_WIDTH-1:0] sub_imm,
  output logic                     sub_last,
  input  logic                     sub_ready,
  input  logic                     sub_uses_imm,
  input  logic                     flush,
  output logic                     if_freeze,
  output logic                     done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [PPC_WIDTH-1:0] len_q;
  logic [PPC_WIDTH:0] p1, p2, nxt, len_w;
  logic accept, step, fin;
  // handshakes, step arithmetic (one bit wider so the end test never wraps) and next state
  always_comb begin
    req_ready = (state == IDLE) & !flush & !rst;
    accept    = req_valid & req_ready & (req_len != '0);
    sub_valid = state == RUN;
    step      = sub_valid & sub_ready & !flush;
    len_w     = {1'b0, len_q};
    p1        = {1'b0, lut_ppc} + (PPC_WIDTH+1)'(1);
    p2        = {1'b0, lut_ppc} + (PPC_WIDTH+1)'(2);
    nxt       = sub_uses_imm ? p2 : p1;
    fin       = nxt >= len_w;
    sub_last  = sub_valid & ((p1 >= len_w) | (sub_uses_imm & (p2 >= len_w)));
    if_freeze = sub_valid | accept;
    sub_word  = sub_valid ? lut_sub : '0;
    sub_imm   = sub_valid ? lut_imm : '0;
    state_nxt = flush ? IDLE : accept ? RUN : (step & fin) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // sequence datapath: flush aborts silently, retirement rewinds ppc and pulses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_index <= '0;
      lut_ppc   <= '0;
      len_q     <= '0;
      done      <= 1'b0;
    end else begin
      done <= step & fin;
      if (flush) lut_ppc <= '0;
      else if (accept) begin
        lut_index <= req_index;
        lut_ppc   <= '0;
        len_q     <= req_len;
      end else if (step) lut_ppc <= fin ? '0 : nxt[PPC_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_obf_seq_ctrl.sv
// tb_obf_seq_ctrl: directed scenarios for the LUT substitution sequencer
module tb_obf_seq_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 1, req_ready, sub_valid, sub_last, sub_ready = 1, sub_uses_imm = 0, flush = 0, if_freeze, done;
  logic [6:0] req_index = 7'd9, lut_index;
  logic [3:0] req_len = 4'd3, lut_ppc;
  logic [15:0] lut_sub, lut_imm, sub_word, sub_imm;
  logic [8:0] st;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign lut_sub = {1'b0, lut_index, 4'h0, lut_ppc};
  assign lut_imm = ~lut_sub;
  assign st = {req_ready, if_freeze, sub_valid, sub_last, done, lut_ppc};

  obf_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index), .req_len(req_len),
    .req_ready(req_ready), .lut_index(lut_index), .lut_ppc(lut_ppc), .lut_sub(lut_sub),
    .lut_imm(lut_imm), .sub_valid(sub_valid), .sub_word(sub_word), .sub_imm(sub_imm),
    .sub_last(sub_last), .sub_ready(sub_ready), .sub_uses_imm(sub_uses_imm), .flush(flush),
    .if_freeze(if_freeze), .done(done)
  );

  function automatic logic [8:0] ex(bit rr, bit fz, bit sv, bit sl, bit dn, int p);
    return {rr, fz, sv, sl, dn, 4'(p)};
  endfunction

  function automatic logic [31:0] wexp(logic [8:0] e, logic [6:0] idx);
    logic [15:0] w;
    w = {1'b0, idx, 4'h0, e[3:0]};
    return e[6] ? {w, ~w} : 32'h0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++; if (st !== 9'h0) begin $display("FAIL reset_status got=%b exp=%b", st, 9'h0); bad++; end
    total++; if (lut_index !== 7'd0) begin $display("FAIL reset_index got=%0d exp=0", lut_index); bad++; end
    @(posedge clk); #1;
    rst = 0; req_valid = 0;
    @(negedge clk);
    total++; if (st !== ex(1,0,0,0,0,0)) begin $display("FAIL reset_release got=%b exp=%b", st, ex(1,0,0,0,0,0)); bad++; end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [8:0] e [6];
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,0,0,0), ex(0,1,1,0,0,1), ex(0,1,1,1,0,2), ex(1,0,0,0,1,0), ex(1,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      req_valid = (i == 0); req_index = 7'd27; req_len = 4'd3; sub_ready = 1; sub_uses_imm = 0;
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL basic c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      total++; if ({sub_word, sub_imm} !== wexp(e[i], 7'd27)) begin $display("FAIL basic c%0d words got=%h exp=%h", i, {sub_word, sub_imm}, wexp(e[i], 7'd27)); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm();
    logic [8:0] e [6];
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,0,0,0), ex(0,1,1,0,0,2), ex(0,1,1,0,0,3), ex(0,1,1,1,0,4), ex(1,0,0,0,1,0)};
    for (int i = 0; i < 6; i++) begin
      req_valid = (i == 0); req_index = 7'd67; req_len = 4'd5; sub_ready = 1; sub_uses_imm = (i == 1);
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL imm c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      total++; if ({sub_word, sub_imm} !== wexp(e[i], 7'd67)) begin $display("FAIL imm c%0d words got=%h exp=%h", i, {sub_word, sub_imm}, wexp(e[i], 7'd67)); bad++; end
      @(posedge clk); #1;
    end
    sub_uses_imm = 0;
  endtask

  task automatic test_stall();
    logic [8:0] e [9];
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,0,0,0), ex(0,1,1,0,0,1), ex(0,1,1,0,0,1), ex(0,1,1,0,0,1),
          ex(0,1,1,0,0,1), ex(0,1,1,0,0,1), ex(0,1,1,1,0,2), ex(1,0,0,0,1,0)};
    for (int i = 0; i < 9; i++) begin
      req_valid = (i == 0); req_index = 7'd5; req_len = 4'd3; sub_ready = !(i >= 2 && i <= 5);
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL stall c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      @(posedge clk); #1;
    end
    sub_ready = 1;
  endtask

  task automatic test_flush();
    logic [8:0] e [7];
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,0,0,0), ex(0,1,1,0,0,1), ex(0,1,1,0,0,2), ex(0,0,0,0,0,0), ex(1,0,0,0,0,0), ex(1,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      req_valid = (i == 0 || i == 3 || i == 4); req_index = (i == 0) ? 7'd99 : 7'd11;
      req_len = (i == 0) ? 4'd8 : 4'd2; flush = (i == 3 || i == 4);
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL flush c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      @(posedge clk); #1;
    end
    total++; if (lut_index !== 7'd99) begin $display("FAIL flush_index got=%0d exp=99", lut_index); bad++; end
  endtask

  task automatic test_len_zero();
    logic [8:0] e [4];
    e = '{ex(1,0,0,0,0,0), ex(1,1,0,0,0,0), ex(0,1,1,1,0,0), ex(1,0,0,0,1,0)};
    for (int i = 0; i < 4; i++) begin
      req_valid = (i < 2); req_index = (i == 0) ? 7'd50 : 7'd12; req_len = (i == 0) ? 4'd0 : 4'd1;
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL len0 c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      total++; if ({sub_word, sub_imm} !== wexp(e[i], 7'd12)) begin $display("FAIL len0 c%0d words got=%h exp=%h", i, {sub_word, sub_imm}, wexp(e[i], 7'd12)); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e [6];
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,1,0,0), ex(1,1,0,0,1,0), ex(0,1,1,0,0,0), ex(0,1,1,1,0,1), ex(1,0,0,0,1,0)};
    for (int i = 0; i < 6; i++) begin
      req_valid = (i == 0 || i == 2); req_index = (i < 2) ? 7'd12 : 7'd40; req_len = (i < 2) ? 4'd1 : 4'd2;
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL b2b c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      total++; if ({sub_word, sub_imm} !== wexp(e[i], (i < 3) ? 7'd12 : 7'd40)) begin $display("FAIL b2b c%0d words got=%h", i, {sub_word, sub_imm}); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] e [4];
    for (int i = 0; i < 6; i++) begin
      req_valid = (i == 0); req_index = 7'd77; req_len = 4'd7;
      @(negedge clk);
      if (i == 5) begin
        total++; if (st !== ex(0,1,1,0,0,4)) begin $display("FAIL rstrun_pre got=%b exp=%b", st, ex(0,1,1,0,0,4)); bad++; end
      end else begin
        @(posedge clk); #1;
      end
    end
    #1 rst = 1; req_valid = 1; req_len = 4'd2;
    #1;
    total++; if (st !== 9'h0) begin $display("FAIL rstrun_async got=%b exp=%b", st, 9'h0); bad++; end
    total++; if ({lut_index, sub_word, sub_imm} !== 39'h0) begin $display("FAIL rstrun_data got=%h exp=0", {lut_index, sub_word, sub_imm}); bad++; end
    @(posedge clk); #1;
    rst = 0;
    e = '{ex(1,1,0,0,0,0), ex(0,1,1,0,0,0), ex(0,1,1,1,0,1), ex(1,0,0,0,1,0)};
    for (int i = 0; i < 4; i++) begin
      req_valid = (i == 0); req_index = 7'd3; req_len = 4'd2;
      @(negedge clk);
      total++; if (st !== e[i]) begin $display("FAIL rstrun_post c%0d status got=%b exp=%b", i, st, e[i]); bad++; end
      total++; if ({sub_word, sub_imm} !== wexp(e[i], 7'd3)) begin $display("FAIL rstrun_post c%0d words got=%h", i, {sub_word, sub_imm}); bad++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_stall();
    test_flush();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
